// File: rtl/exec_unit_mc_if.sv
// Handshake and operand/result bus for the multi-cycle execution unit.
interface exec_unit_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] imm;
    logic [1:0]       sel_b;
    logic             swap;
    logic [2:0]       op;
    logic [2:0]       cond_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ex_res;
    logic             cond_out;
    logic             busy;

    modport master (
        output in_valid, data1, data2, imm, sel_b, swap, op, cond_sel, out_ready,
        input  in_ready, out_valid, ex_res, cond_out, busy
    );

    modport slave (
        input  in_valid, data1, data2, imm, sel_b, swap, op, cond_sel, out_ready,
        output in_ready, out_valid, ex_res, cond_out, busy
    );
endinterface

// File: rtl/exec_unit_mc.sv
// Execution unit: single-cycle ALU ops plus a radix-2 shift-add multiplier,
// with a registered result/condition held under valid/ready backpressure.
module exec_unit_mc #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           rst,
    exec_unit_mc_if.slave bus
);
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpSlt  = 3'd5;
    localparam logic [2:0] OpMul  = 3'd6;
    localparam logic [2:0] OpPass = 3'd7;

    localparam logic [2:0] CondZero = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] ex_res_q;
    logic             cond_out_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNTW-1:0]  cnt_q;
    logic [2:0]       cond_sel_q;
    logic             cond_pre_q;

    logic             in_ready;
    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             ovf;
    logic             lt;
    logic             eq;
    logic             carry;
    logic [WIDTH-1:0] alu_res;
    logic             flag;
    logic [WIDTH-1:0] acc_next;

    assign in_ready      = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign mul_last      = (state_q == StMul) && (cnt_q == CNTW'(WIDTH - 1));
    assign acc_next      = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q == StMul);
    assign bus.out_valid = out_valid_q;
    assign bus.ex_res    = ex_res_q;
    assign bus.cond_out  = cond_out_q;

    // Operand muxing, ALU result and condition flags for the presented operation.
    always_comb begin
        b_mux = '0;
        unique case (bus.sel_b)
            2'd0: b_mux = '0;
            2'd1: b_mux = bus.data2;
            2'd2: b_mux = bus.imm;
            2'd3: b_mux = '1;
            default: b_mux = '0;
        endcase
        opa     = bus.swap ? b_mux : bus.data1;
        opb     = bus.swap ? bus.data1 : b_mux;
        sum_add = {1'b0, opa} + {1'b0, opb};
        sum_sub = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
        // Signed overflow of A-B: operand signs differ and result sign differs from A.
        ovf     = (opa[WIDTH-1] != opb[WIDTH-1]) && (sum_sub[WIDTH-1] != opa[WIDTH-1]);
        lt      = sum_sub[WIDTH-1] ^ ovf;
        eq      = (opa == opb);
        carry   = (bus.op == OpAdd) ? sum_add[WIDTH] : sum_sub[WIDTH];

        alu_res = '0;
        unique case (bus.op)
            OpAdd:  alu_res = sum_add[WIDTH-1:0];
            OpSub:  alu_res = sum_sub[WIDTH-1:0];
            OpAnd:  alu_res = opa & opb;
            OpOr:   alu_res = opa | opb;
            OpXor:  alu_res = opa ^ opb;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OpMul:  alu_res = '0;
            OpPass: alu_res = opb;
            default: alu_res = '0;
        endcase

        flag = 1'b0;
        unique case (bus.cond_sel)
            3'd0: flag = 1'b1;
            3'd1: flag = lt;
            3'd2: flag = lt | eq;
            3'd3: flag = !lt;
            3'd4: flag = eq;
            3'd5: flag = !eq;
            3'd6: flag = (alu_res == '0);
            3'd7: flag = carry;
            default: flag = 1'b0;
        endcase
    end

    // FSM next-state: Idle -> Mul on a multiply, Mul -> Hold after the last bit,
    // Hold -> Idle once the consumer takes the product.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && bus.op == OpMul) state_d = StMul;
            StMul:  if (mul_last) state_d = StHold;
            StHold: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Datapath: capture at acceptance, iterate the multiplier, retire on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_res_q    <= '0;
            cond_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            cond_sel_q  <= '0;
            cond_pre_q  <= 1'b0;
        end else if (accept) begin
            acc_q      <= '0;
            mcand_q    <= opa;
            mplier_q   <= opb;
            cnt_q      <= '0;
            cond_sel_q <= bus.cond_sel;
            cond_pre_q <= flag;
            if (bus.op == OpMul) begin
                out_valid_q <= 1'b0;
            end else begin
                ex_res_q    <= alu_res;
                cond_out_q  <= flag;
                out_valid_q <= 1'b1;
            end
        end else if (state_q == StMul) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNTW'(1);
            if (mul_last) begin
                ex_res_q    <= acc_next;
                // Zero flag depends on the product; all other flags were fixed at acceptance.
                cond_out_q  <= (cond_sel_q == CondZero) ? (acc_next == '0) : cond_pre_q;
                out_valid_q <= 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed and randomized self-checking bench for exec_unit_mc (WIDTH=16).
module tb_exec_unit_mc;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    exec_unit_mc_if #(.WIDTH(W)) bus ();

    exec_unit_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: result and condition from plain arithmetic on the operands.
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [2:0] cs,
                                      output logic [W-1:0] r, output logic c);
        int unsigned ua, ub, prod;
        int          sa, sb;
        logic        cy;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        prod = ua * ub;
        case (op)
            3'd0: r = W'(ua + ub);
            3'd1: r = W'(ua - ub);
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = W'(prod);
            default: r = b;
        endcase
        cy = (op == 3'd0) ? ((ua + ub) > 32'hFFFF) : (ua >= ub);
        case (cs)
            3'd0: c = 1'b1;
            3'd1: c = (sa < sb);
            3'd2: c = (sa <= sb);
            3'd3: c = (sa >= sb);
            3'd4: c = (a == b);
            3'd5: c = (a != b);
            3'd6: c = (r == 0);
            default: c = cy;
        endcase
    endfunction

    function automatic void operands(input logic [W-1:0] d1, input logic [W-1:0] d2,
                                     input logic [W-1:0] im, input logic [1:0] sb,
                                     input logic sw, output logic [W-1:0] a,
                                     output logic [W-1:0] b);
        logic [W-1:0] bm;
        case (sb)
            2'd0: bm = 0;
            2'd1: bm = d2;
            2'd2: bm = im;
            default: bm = {W{1'b1}};
        endcase
        a = sw ? bm : d1;
        b = sw ? d1 : bm;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic [W-1:0] im, input logic [1:0] sb, input logic sw,
                         input logic [2:0] cs);
        bus.op       = op;
        bus.data1    = d1;
        bus.data2    = d2;
        bus.imm      = im;
        bus.sel_b    = sb;
        bus.swap     = sw;
        bus.cond_sel = cs;
    endtask

    task automatic scramble();
        bus.op       = 3'($urandom);
        bus.cond_sel = 3'($urandom);
        bus.data1    = W'($urandom);
        bus.data2    = W'($urandom);
        bus.imm      = W'($urandom);
        bus.sel_b    = 2'($urandom);
        bus.swap     = 1'($urandom);
    endtask

    task automatic make_ready();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        #1;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        check("ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    // Issue one op, wait for its result, check latency/value/condition, then stall `hold` cycles.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                          input logic [W-1:0] im, input logic [1:0] sb, input logic sw,
                          input logic [2:0] cs, input int hold);
        logic [W-1:0] a, b, er;
        logic         ec;
        int           lat, exp_lat;
        operands(d1, d2, im, sb, sw, a, b);
        ref_model(op, a, b, cs, er, ec);
        exp_lat = (op == 3'd6) ? W : 0;
        make_ready();
        drive(op, d1, d2, im, sb, sw, cs);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        scramble();
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (op == 3'd6) begin
                check("mul_busy", 64'(bus.busy), 64'd1);
                check("mul_in_ready", 64'(bus.in_ready), 64'd0);
                bus.in_valid = 1'b1;
            end
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("ex_res", 64'(bus.ex_res), 64'(er));
        check("cond_out", 64'(bus.cond_out), 64'(ec));
        check("busy_done", 64'(bus.busy), 64'd0);
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                step();
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_res", 64'(bus.ex_res), 64'(er));
                check("hold_cond", 64'(bus.cond_out), 64'(ec));
            end
        end
    endtask

    initial begin
        logic [W-1:0] a, b, er;
        logic         ec;
        n_cmp  = 0;
        n_fail = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, '0, '0, '0, 2'd0, 1'b0, 3'd0);
        step();
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ex_res", 64'(bus.ex_res), 64'd0);
        check("rst_cond", 64'(bus.cond_out), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Add overflow into sign bit with carry condition, then wrap to zero.
        run_op(3'd0, 16'h7FFF, 16'h0001, 16'h0000, 2'd1, 1'b0, 3'd7, 0);
        check("add_8000", 64'(bus.ex_res), 64'h8000);
        run_op(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 2'd1, 1'b0, 3'd6, 0);
        check("add_zero_flag", 64'(bus.cond_out), 64'd1);

        // Swapped subtract with immediate.
        run_op(3'd1, 16'd5, 16'h0000, 16'd3, 2'd2, 1'b1, 3'd1, 0);
        check("sub_fffe", 64'(bus.ex_res), 64'hFFFE);

        // Multiply: 16 busy cycles checked inside run_op.
        run_op(3'd6, 16'h0123, 16'h0010, 16'h0000, 2'd1, 1'b0, 3'd0, 0);
        check("mul_1230", 64'(bus.ex_res), 64'h1230);
        run_op(3'd6, 16'h1234, 16'h0000, 16'h0000, 2'd0, 1'b0, 3'd6, 1);
        run_op(3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 2'd1, 1'b0, 3'd7, 2);

        // XOR stalled 5 cycles, next op accepted on the cycle out_ready rises.
        run_op(3'd4, 16'hA5A5, 16'h0FF0, 16'h0000, 2'd1, 1'b0, 3'd5, 5);
        bus.out_ready = 1'b1;
        #1;
        check("same_cycle_ready", 64'(bus.in_ready), 64'd1);
        run_op(3'd3, 16'h1200, 16'h0034, 16'h0000, 2'd1, 1'b0, 3'd4, 0);

        // Back-to-back adds, one result per cycle.
        make_ready();
        for (int i = 0; i < 8; i++) begin
            drive(3'd0, W'($urandom), W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
                  3'($urandom));
            operands(bus.data1, bus.data2, bus.imm, bus.sel_b, bus.swap, a, b);
            ref_model(3'd0, a, b, bus.cond_sel, er, ec);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
            step();
            check("b2b_valid", 64'(bus.out_valid), 64'd1);
            check("b2b_res", 64'(bus.ex_res), 64'(er));
            check("b2b_cond", 64'(bus.cond_out), 64'(ec));
        end
        bus.in_valid = 1'b0;

        // Reset in the middle of a multiply.
        make_ready();
        drive(3'd6, 16'h00FF, 16'h0101, 16'h0000, 2'd1, 1'b0, 3'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        check("mid_mul_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_res", 64'(bus.ex_res), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        run_op(3'd0, 16'h0102, 16'h0304, 16'h0000, 2'd1, 1'b0, 3'd0, 0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom),
                   1'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
